// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared state encoding and driver constants for psram_arbiter
// Contents: arbiter FSM state type, read_write command codes, endcommand guard count.
package psram_arb_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        BUSY      = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic [1:0] RW_IDLE  = 2'd0;
    localparam logic [1:0] RW_WRITE = 2'd1;
    localparam logic [1:0] RW_READ  = 2'd2;

    // BUSY cycles after quad_start during which endcommand is not trusted
    localparam int ENDCMD_GUARD = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with registered priority pointer
// Ports: clk, rst (sync, active-high); req[1:0] requests; advance commits the
// current grant and moves priority to the other requester; grant[1:0] one-hot.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Requester that wins when both request; 0 after reset
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (prio == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    // After serving requester 0 the other one gets priority, and vice versa
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-requester arbiter in front of a QPI PSRAM driver
// Ports: mem_clk, rst (sync, active-high).
//   Requester N in {0,1}: reqN_valid/we/addr/wdata in; reqN_ready (accept pulse),
//   reqN_done (completion pulse), reqN_rdata (read data, held), reqN_err (timeout pulse) out.
//   Driver side: qpi_on, endcommand, data_out in; address, read_write, quad_start,
//   data_in, busy out.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int GAP_CYC = 2
) (
    input  logic              mem_clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,

    input  logic              qpi_on,
    input  logic              endcommand,
    input  logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        read_write,
    output logic              quad_start,
    output logic [DATA_W-1:0] data_in,
    output logic              busy
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] GUARD_C   = CNT_W'(ENDCMD_GUARD);
    localparam logic [CNT_W-1:0] LAST_BUSY = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC);

    state_t            state;
    state_t            state_next;

    // In ISSUE/BUSY: cycles since quad_start. In GAP: GAP cycles elapsed.
    logic [CNT_W-1:0]  cnt;

    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        grant;
    logic              take;
    logic              end_ok;
    logic              timed_out;

    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign take = (state == IDLE) && qpi_on && (grant != 2'b00);

    rr_arb2 u_rr (
        .clk     (mem_clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (take),
        .grant   (grant)
    );

    // endcommand only counts once the guard window after quad_start has passed.
    // The last BUSY cycle is quad_start+TIMEOUT-1 so that err lands at quad_start+TIMEOUT.
    assign end_ok    = (state == BUSY) && endcommand && (cnt > GUARD_C);
    assign timed_out = (state == BUSY) && !end_ok && (cnt == LAST_BUSY);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state <= WAIT_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!qpi_on) begin
            state_next = WAIT_INIT;
        end else begin
            case (state)
                WAIT_INIT: state_next = IDLE;
                IDLE:      if (grant != 2'b00) state_next = ISSUE;
                ISSUE:     state_next = BUSY;
                BUSY:      if (end_ok || timed_out) state_next = GAP;
                GAP:       if (cnt == GAP_LAST) state_next = IDLE;
                default:   state_next = WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            cnt      <= '0;
            owner    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 2'b00;

            if (take) begin
                owner   <= grant[1];
                we_q    <= grant[1] ? req1_we    : req0_we;
                addr_q  <= grant[1] ? req1_addr  : req0_addr;
                wdata_q <= grant[1] ? req1_wdata : req0_wdata;
            end

            case (state)
                ISSUE:   cnt <= CNT_ONE;
                BUSY:    cnt <= (end_ok || timed_out) ? CNT_ONE : cnt + CNT_ONE;
                GAP:     cnt <= cnt + CNT_ONE;
                default: cnt <= '0;
            endcase

            // Losing qpi_on aborts silently: no completion, no error, no capture
            if (qpi_on && end_ok) begin
                done_q[owner] <= 1'b1;
                if (!we_q) begin
                    if (owner) rdata1_q <= data_out;
                    else       rdata0_q <= data_out;
                end
            end else if (qpi_on && timed_out) begin
                err_q[owner] <= 1'b1;
            end
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        quad_start = 1'b0;
        read_write = RW_IDLE;
        address    = '0;
        data_in    = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = qpi_on && grant[0];
                req1_ready = qpi_on && grant[1];
            end
            ISSUE, BUSY: begin
                busy = 1'b1;
                // Command lines drop in the same cycle qpi_on falls
                if (qpi_on) begin
                    quad_start = (state == ISSUE);
                    read_write = we_q ? RW_WRITE : RW_READ;
                    address    = addr_q;
                    data_in    = wdata_q;
                end
            end
            GAP: busy = 1'b1;
            default: ;
        endcase
    end

    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - self-checking bench for psram_arbiter
module tb_psram_arbiter;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;
    localparam int GAP_CYC = 2;
    localparam int GUARD   = 2;

    logic              mem_clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_we, req0_ready, req0_done, req0_err;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, req0_rdata;
    logic              req1_valid, req1_we, req1_ready, req1_done, req1_err;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, req1_rdata;
    logic              qpi_on, endcommand, quad_start, busy;
    logic [DATA_W-1:0] data_out, data_in;
    logic [ADDR_W-1:0] address;
    logic [1:0]        read_write;

    logic [9:0]        ctl;
    assign ctl = {quad_start, read_write, busy, req1_ready, req0_ready,
                  req1_done, req0_done, req1_err, req0_err};

    int                n_run  = 0;
    int                n_fail = 0;
    int                last_grant;
    logic [DATA_W-1:0] rdata_model [2];

    always #5 mem_clk = ~mem_clk;

    psram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
    ) dut (
        .mem_clk(mem_clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .qpi_on(qpi_on), .endcommand(endcommand), .data_out(data_out),
        .address(address), .read_write(read_write), .quad_start(quad_start),
        .data_in(data_in), .busy(busy)
    );

    // Inputs change 1 ns after the rising edge; outputs are read at the falling edge.
    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // One full transaction starting at the drive point of an IDLE cycle.
    // lat = cycles from quad_start to the endcommand pulse (3..TIMEOUT-1), 0 = never.
    task automatic do_xfer(input string tag, input logic v0, input logic v1,
                           input logic we0, input logic we1,
                           input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                           input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                           input int lat, input logic [DATA_W-1:0] rd);
        int                w;
        int                last_k;
        logic [1:0]        w_oh;
        logic              wwe;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [1:0]        rw_e;
        logic [9:0]        exp_ctl;

        if (v0 && v1) w = 1 - last_grant;
        else          w = v1 ? 1 : 0;
        w_oh   = (w == 1) ? 2'b10 : 2'b01;
        wwe    = (w == 1) ? we1 : we0;
        wa     = (w == 1) ? a1 : a0;
        wd     = (w == 1) ? d1 : d0;
        rw_e   = wwe ? 2'd1 : 2'd2;
        last_k = (lat == 0) ? TIMEOUT - 1 : lat;

        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        endcommand = 1'b0;
        settle();
        exp_ctl = {1'b0, 2'd0, 1'b0, w_oh, 2'b00, 2'b00};
        n_run++;
        if (ctl !== exp_ctl) begin
            n_fail++;
            $display("FAIL %s grant: ctl=%b expected %b", tag, ctl, exp_ctl);
        end
        tick();
        last_grant = w;

        // k=0 is the quad_start cycle; endcommand is noise inside the guard window
        for (int k = 0; k <= last_k; k++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            endcommand = (k <= GUARD) ? 1'($urandom_range(0, 1)) : (lat != 0 && k == lat);
            data_out   = (lat != 0 && k == lat) ? rd : DATA_W'($urandom);
            settle();
            exp_ctl = {(k == 0), rw_e, 1'b1, 2'b00, 2'b00, 2'b00};
            n_run++;
            if (ctl !== exp_ctl || address !== wa || data_in !== wd) begin
                n_fail++;
                $display("FAIL %s busy k=%0d: ctl=%b addr=%h din=%h expected ctl=%b addr=%h din=%h",
                         tag, k, ctl, address, data_in, exp_ctl, wa, wd);
            end
            tick();
        end

        endcommand = 1'b0;
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        settle();
        if (lat != 0 && !wwe) rdata_model[w] = rd;
        exp_ctl = {1'b0, 2'd0, 1'b1, 2'b00, (lat != 0) ? w_oh : 2'b00, (lat == 0) ? w_oh : 2'b00};
        n_run++;
        if (ctl !== exp_ctl || req0_rdata !== rdata_model[0] || req1_rdata !== rdata_model[1]) begin
            n_fail++;
            $display("FAIL %s finish: ctl=%b rd0=%h rd1=%h expected ctl=%b rd0=%h rd1=%h",
                     tag, ctl, req0_rdata, req1_rdata, exp_ctl, rdata_model[0], rdata_model[1]);
        end
        tick();

        for (int g = 1; g < GAP_CYC; g++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            settle();
            n_run++;
            if (ctl !== 10'b0_00_1_00_00_00) begin
                n_fail++;
                $display("FAIL %s gap %0d: ctl=%b expected %b", tag, g, ctl, 10'b0_00_1_00_00_00);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; qpi_on = 1'b0; endcommand = 1'b0; data_out = '0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        repeat (3) tick();
        settle();
        n_run++;
        if ({ctl, address, data_in, req0_rdata, req1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset: ctl=%b addr=%h din=%h rd0=%h rd1=%h expected all 0",
                     ctl, address, data_in, req0_rdata, req1_rdata);
        end
        tick();
        qpi_on = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        settle();
        n_run++;
        if (ctl !== '0) begin
            n_fail++;
            $display("FAIL reset_held: ctl=%b expected 0", ctl);
        end
        tick();
        last_grant     = 1;
        rdata_model[0] = '0;
        rdata_model[1] = '0;
    endtask

    task automatic test_init_write();
        int bad;
        bad = 0;
        rst = 1'b0; qpi_on = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 23'h000123; req0_wdata = 16'hBEEF;
        req1_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            settle();
            if (req0_ready || req1_ready || quad_start || busy) bad++;
            tick();
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wait_init: %0d cycles with activity, expected 0", bad);
        end
        qpi_on = 1'b1;
        settle();
        n_run++;
        if (req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_edge: req0_ready=%b expected 0", req0_ready);
        end
        tick();
        do_xfer("init_write", 1'b1, 1'b0, 1'b1, 1'b0, 23'h000123, '0, 16'hBEEF, '0, 5, '0);
    endtask

    task automatic test_read();
        do_xfer("read1", 1'b0, 1'b1, 1'b0, 1'b0, '0, 23'h7FFFFF, '0, '0, 9, 16'hA5C3);
        n_run++;
        if (req1_rdata !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL read1_hold: req1_rdata=%h expected a5c3", req1_rdata);
        end
    endtask

    task automatic test_timeout();
        do_xfer("timeout0", 1'b1, 1'b0, 1'b0, 1'b0, 23'h000777, '0, '0, '0, 0, 16'h1234);
        do_xfer("after_to", 1'b1, 1'b1, 1'b0, 1'b1, 23'h000010, 23'h000020,
                16'h0101, 16'h0202, 4, 16'h5A5A);
    endtask

    task automatic test_back_to_back();
        int owners [$];
        int qs_cyc [$];
        int done_n;
        int err_n;
        int last_qs;
        int first;
        done_n = 0; err_n = 0; last_qs = -100;
        first = 1 - last_grant;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 23'h000aaa; req0_wdata = 16'h1111;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 23'h000bbb; req1_wdata = 16'h2222;
        for (int c = 0; c < 40; c++) begin
            endcommand = (c == last_qs + 3);
            settle();
            if (req0_ready) owners.push_back(0);
            if (req1_ready) owners.push_back(1);
            if (quad_start) begin
                qs_cyc.push_back(c);
                last_qs = c;
            end
            if (req0_done || req1_done) done_n++;
            if (req0_err || req1_err) err_n++;
            tick();
            if (owners.size() >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        endcommand = 1'b0;
        n_run++;
        if (owners.size() != 4 || qs_cyc.size() != 4 || done_n != 4 || err_n != 0) begin
            n_fail++;
            $display("FAIL b2b_counts: grants=%0d qs=%0d done=%0d err=%0d expected 4 4 4 0",
                     owners.size(), qs_cyc.size(), done_n, err_n);
        end
        for (int i = 0; i < owners.size(); i++) begin
            n_run++;
            if (owners[i] != (first + i) % 2) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: grant=%0d expected %0d", i, owners[i], (first + i) % 2);
            end
        end
        for (int i = 1; i < qs_cyc.size(); i++) begin
            n_run++;
            if (qs_cyc[i] - qs_cyc[i-1] != 1 + 3 + GAP_CYC + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: %0d cycles expected %0d",
                         i, qs_cyc[i] - qs_cyc[i-1], 1 + 3 + GAP_CYC + 1);
            end
        end
        last_grant = (first + 3) % 2;
    endtask

    task automatic test_random();
        int v;
        int r;
        int lat;
        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(1, 3);
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT - 1 : $urandom_range(3, 12);
            do_xfer($sformatf("rand%0d", i), v[0], v[1],
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ADDR_W'($urandom), ADDR_W'($urandom),
                    DATA_W'($urandom), DATA_W'($urandom), lat, DATA_W'($urandom));
        end
    endtask

    task automatic test_abort_rst();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 23'h0abcde; req0_wdata = 16'h7777;
        settle();
        n_run++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_abort_grant: req0_ready=%b expected 1", req0_ready);
        end
        tick();
        last_grant = 0;
        req0_valid = 1'b0;
        repeat (4) tick();
        endcommand = 1'b1; data_out = 16'hDEAD; rst = 1'b1;
        tick();
        endcommand = 1'b0;
        settle();
        n_run++;
        if ({ctl, address, data_in, req0_rdata, req1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_abort: ctl=%b addr=%h din=%h rd0=%h rd1=%h expected all 0",
                     ctl, address, data_in, req0_rdata, req1_rdata);
        end
        rst = 1'b0;
        last_grant = 1;
        rdata_model[0] = '0;
        rdata_model[1] = '0;
        tick();
        settle();
        n_run++;
        if (ctl !== '0) begin
            n_fail++;
            $display("FAIL rst_abort_after: ctl=%b expected 0", ctl);
        end
        tick();
    endtask

    task automatic test_abort_qpi();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 23'h012345; req1_wdata = 16'h0;
        settle();
        n_run++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL qpi_abort_grant: req1_ready=%b expected 1", req1_ready);
        end
        tick();
        last_grant = 1;
        req1_valid = 1'b0;
        repeat (4) tick();
        qpi_on = 1'b0; endcommand = 1'b1; data_out = 16'hBAD0;
        settle();
        n_run++;
        if (quad_start !== 1'b0 || read_write !== 2'd0) begin
            n_fail++;
            $display("FAIL qpi_drop_now: quad_start=%b read_write=%0d expected 0 0", quad_start, read_write);
        end
        tick();
        endcommand = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_run++;
            if (ctl !== '0 || address !== '0 || data_in !== '0 ||
                req0_rdata !== rdata_model[0] || req1_rdata !== rdata_model[1]) begin
                n_fail++;
                $display("FAIL qpi_drop %0d: ctl=%b addr=%h din=%h rd1=%h expected 0 0 0 %h",
                         i, ctl, address, data_in, req1_rdata, rdata_model[1]);
            end
            tick();
        end
        qpi_on = 1'b1;
        tick();
        do_xfer("recover", 1'b1, 1'b1, 1'b0, 1'b0, 23'h000042, 23'h000043,
                '0, '0, 6, 16'hC0DE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_random();
        test_abort_rst();
        test_abort_qpi();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
